// File: rtl/nonce_reporter_pkg.sv
// Shared types and helpers for the golden-nonce reporter: FSM states, frame
// geometry, default header byte and the frame checksum.
package nonce_reporter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    // Header + four nonce bytes + checksum.
    localparam int FRAME_LEN = 6;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h55;

    function automatic logic [7:0] frame_csum(input logic [31:0] word);
        return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Small single-clock FIFO: write-through-pointer memory with a combinational
// read of the head entry, registered full flag and occupancy count.
module nonce_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q;
    logic             push_ok, pop_ok;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && (!full_q || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/nonce_reporter.sv
// Buffers golden nonces and serialises each one as a 6-byte frame
// (header, nonce MSB first, XOR checksum) on a byte-wide valid/ready stream.
module nonce_reporter
    import nonce_reporter_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT,
    parameter int         DROP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nonce_valid,
    input  logic [31:0]       nonce,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              fifo_full,
    output logic [DROP_W-1:0] dropped_count
);
    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 3);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              pop_en, push_en, drop_en, handshake;
    logic [31:0]       fifo_data;
    logic              fifo_full_w, fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign pop_en    = (state_q == ST_IDLE) && !fifo_empty;
    assign push_en   = nonce_valid && ((fifo_count != CNT_FULL) || pop_en);
    assign drop_en   = nonce_valid && !push_en;
    assign handshake = tx_valid_q && tx_ready;

    nonce_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_en),
        .push_data_i (nonce),
        .pop_i       (pop_en),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full_w),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // tx_data is loaded one byte ahead so the stream outputs stay registered.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_en) begin
                    state_d    = ST_HDR;
                    shift_d    = fifo_data;
                    csum_d     = frame_csum(fifo_data);
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                end
            end
            ST_HDR: begin
                if (handshake) begin
                    state_d   = ST_DATA;
                    idx_d     = 2'd0;
                    tx_data_d = shift_q[31:24];
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_CSUM;
                        tx_data_d = csum_q;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        shift_d   = {shift_q[23:0], 8'h00};
                        tx_data_d = shift_q[23:16];
                    end
                end
            end
            ST_CSUM: begin
                if (handshake) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_en && !(&drop_q)) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign fifo_full     = fifo_full_w;
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_nonce_reporter.sv
// Self-checking bench for nonce_reporter: queue-based frame model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_nonce_reporter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nonce_valid = 1'b0;
    logic [31:0] nonce = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid, tx_valid2, fifo_full, fifo_full2;
    logic [7:0]  tx_data, tx_data2;
    logic [15:0] dropped_count;
    logic [3:0]  dropped_count2;

    int n_cmp = 0;
    int n_bad = 0;
    int base;

    nonce_reporter #(.DEPTH(DEPTH), .HDR_BYTE(8'h55), .DROP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .nonce_valid(nonce_valid), .nonce(nonce),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .fifo_full(fifo_full), .dropped_count(dropped_count)
    );

    nonce_reporter #(.DEPTH(DEPTH), .HDR_BYTE(8'h55), .DROP_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .nonce_valid(nonce_valid), .nonce(nonce),
        .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready),
        .fifo_full(fifo_full2), .dropped_count(dropped_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: nonces waiting, bytes of the frame on the wire, and a loss count.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_frame[$];
    logic [31:0] m_word;
    int          m_drops = 0;
    bit          m_pop, m_hs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_frame.delete();
            m_drops = 0;
        end else begin
            m_pop = (m_frame.size() == 0) && (m_fifo.size() > 0);
            m_hs  = (m_frame.size() > 0) && tx_ready;
            if (nonce_valid) begin
                if (m_fifo.size() < DEPTH || m_pop) m_fifo.push_back(nonce);
                else m_drops++;
            end
            if (m_hs) void'(m_frame.pop_front());
            if (m_pop) begin
                m_word  = m_fifo.pop_front();
                m_frame = '{8'h55, m_word[31:24], m_word[23:16], m_word[15:8], m_word[7:0],
                            m_word[31:24] ^ m_word[23:16] ^ m_word[15:8] ^ m_word[7:0]};
            end
        end
    end

    // Accepted bytes, and the previous cycle's stall state for the stream rules.
    logic [7:0] cap[$];
    logic       stall_q = 1'b0;
    logic [7:0] prev_data_q = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            stall_q     <= tx_valid && !tx_ready;
            prev_data_q <= tx_data;
        end
    end

    always @(negedge clk) begin
        if (stall_q) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(prev_data_q));
        end
        check("tx_valid", 32'(tx_valid), 32'(m_frame.size() > 0));
        check("sat_tx_valid", 32'(tx_valid2), 32'(m_frame.size() > 0));
        if (m_frame.size() > 0) begin
            check("tx_data", 32'(tx_data), 32'(m_frame[0]));
            check("sat_tx_data", 32'(tx_data2), 32'(m_frame[0]));
        end
        check("fifo_full", 32'(fifo_full), 32'(m_fifo.size() == DEPTH));
        check("dropped", 32'(dropped_count), (m_drops > 65535) ? 32'd65535 : 32'(m_drops));
        check("sat_dropped", 32'(dropped_count2), (m_drops > 15) ? 32'd15 : 32'(m_drops));
    end

    task automatic wait_bytes(input int target, input int budget);
        int n = 0;
        while (cap.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_bytes", 32'(cap.size() >= target), 32'd1);
    endtask

    task automatic pulse(input logic [31:0] v);
        nonce_valid = 1'b1;
        nonce = v;
        @(negedge clk);
        nonce_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_dropped", 32'(dropped_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single nonce with the sink always ready.
        tx_ready = 1'b1;
        base = cap.size();
        pulse(32'h12345678);
        check("lat_t1_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(tx_valid), 32'd1);
        check("lat_t2_hdr", 32'(tx_data), 32'h55);
        wait_bytes(base + 6, 50);
        check("basic_b0", 32'(cap[base]), 32'h55);
        check("basic_b1", 32'(cap[base+1]), 32'h12);
        check("basic_b2", 32'(cap[base+2]), 32'h34);
        check("basic_b3", 32'(cap[base+3]), 32'h56);
        check("basic_b4", 32'(cap[base+4]), 32'h78);
        check("basic_b5", 32'(cap[base+5]), 32'h08);
        @(negedge clk);
        check("basic_idle", 32'(tx_valid), 32'd0);
        check("basic_drops", 32'(dropped_count), 32'd0);

        // Same nonce under back-pressure: 1-0-0-1 then random.
        base = cap.size();
        pulse(32'h12345678);
        for (int i = 0; i < 200 && cap.size() < base + 6; i++) begin
            tx_ready = (i < 4) ? ((i == 0 || i == 3) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("bp_done", 32'(cap.size() >= base + 6), 32'd1);
        check("bp_b0", 32'(cap[base]), 32'h55);
        check("bp_b2", 32'(cap[base+2]), 32'h34);
        check("bp_b5", 32'(cap[base+5]), 32'h08);
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Overflow: seven nonces into a stalled link.
        tx_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            pulse(32'(k));
            nonce_valid = 1'b1;
            if (k == 4) check("ovf_full_after4", 32'(fifo_full), 32'd0);
            if (k == 5) check("ovf_full_after5", 32'(fifo_full), 32'd1);
        end
        nonce_valid = 1'b0;
        check("ovf_dropped", 32'(dropped_count), 32'd2);
        tx_ready = 1'b1;
        base = cap.size();
        wait_bytes(base + 30, 100);
        for (int k = 0; k < 5; k++) begin
            check("ovf_hdr", 32'(cap[base+6*k]), 32'h55);
            check("ovf_lsb", 32'(cap[base+6*k+4]), 32'(k + 1));
            check("ovf_csum", 32'(cap[base+6*k+5]), 32'(k + 1));
        end
        repeat (4) @(negedge clk);
        check("ovf_no_extra", 32'(cap.size()), 32'(base + 30));

        // Push into a full FIFO on the same edge as the IDLE pop.
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) pulse(32'hA0 + 32'(k));
        check("pp_full", 32'(fifo_full), 32'd1);
        tx_ready = 1'b1;
        base = cap.size();
        wait_bytes(base + 6, 50);
        check("pp_full_idle", 32'(fifo_full), 32'd1);
        pulse(32'hB0);
        check("pp_full_kept", 32'(fifo_full), 32'd1);
        check("pp_no_drop", 32'(dropped_count), 32'd2);
        wait_bytes(base + 36, 100);
        for (int k = 0; k < 6; k++)
            check("pp_order", 32'(cap[base+6*k+4]), (k < 5) ? 32'hA0 + 32'(k) : 32'hB0);
        repeat (3) @(negedge clk);

        // Reset mid-frame in DATA idx 2 with two nonces still queued.
        tx_ready = 1'b0;
        pulse(32'hCAFEBABE);
        pulse(32'h11111111);
        pulse(32'h22222222);
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        check("mid_data_idx2", 32'(tx_data), 32'hBA);
        #2 rst_n = 1'b0;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'd0);
        check("async_fifo_full", 32'(fifo_full), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        base = cap.size();
        repeat (10) @(negedge clk);
        check("rst_no_bytes", 32'(cap.size()), 32'(base));
        pulse(32'h0BADF00D);
        wait_bytes(base + 6, 50);
        check("rst_b0", 32'(cap[base]), 32'h55);
        check("rst_b1", 32'(cap[base+1]), 32'h0B);
        check("rst_b4", 32'(cap[base+4]), 32'h0D);
        check("rst_b5", 32'(cap[base+5]), 32'h5B);
        repeat (3) @(negedge clk);

        // Saturation: 25 nonces into a stalled link, 20 of them lost.
        tx_ready = 1'b0;
        nonce_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            nonce = 32'h100 + 32'(i);
            @(negedge clk);
        end
        nonce_valid = 1'b0;
        check("sat_wide", 32'(dropped_count), 32'd20);
        check("sat_narrow", 32'(dropped_count2), 32'hF);
        tx_ready = 1'b1;
        base = cap.size();
        wait_bytes(base + 30, 100);
        check("sat_first_b3", 32'(cap[base+3]), 32'h01);
        check("sat_narrow_held", 32'(dropped_count2), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
